accel_mmio_ctrl: RTL and testbench

- Memory-mapped controller between the picoRV32 native memory bus and the MNIST NN accelerator.
- Owns the 784-word pixel buffer that drives the accelerator image input.
- Sequences each inference: reset pulse to the accelerator, wait for ready, latch the 10 class scores, compute argmax.
- Exposes status, scores, class index, cycle count and an optional interrupt to firmware.

---
 rtl/accel_pkg.sv | 36 +++
 rtl/accel_argmax.sv | 64 ++++++
 rtl/accel_mmio_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_accel_mmio_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared definitions for the MNIST accelerator MMIO controller.
//   - register window offsets (byte offsets from the window base)
//   - pixel and class counts, datapath word width
//   - controller state encoding
//   - STATUS / CTRL bit positions
package accel_pkg;

  localparam int DATA_W = 32;
  localparam int NPIX   = 784;
  localparam int NCLASS = 10;
  localparam int IDX_W  = 4;

  localparam logic [11:0] OFF_PIXEL  = 12'h000;
  localparam logic [11:0] OFF_CTRL   = 12'hC40;
  localparam logic [11:0] OFF_STATUS = 12'hC44;
  localparam logic [11:0] OFF_CLASS  = 12'hC48;
  localparam logic [11:0] OFF_CYCLES = 12'hC4C;
  localparam logic [11:0] OFF_SCORE  = 12'hC50;
  localparam logic [11:0] OFF_SCORE_LIMIT = 12'hC78;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_ERROR = 2;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_RST,
    S_RUN,
    S_ARGMAX,
    S_DONE
  } state_t;

endpackage

// File: rtl/accel_argmax.sv
// accel_argmax: sequential signed argmax over NCLASS words.
//   clk, reset (async, active-low)
//   start  : one-cycle pulse, begins a scan of k = 0..NCLASS-1 (one word per cycle)
//   scores : NCLASS packed signed words, word k at [DATA_W*k +: DATA_W]; held stable during scan
//   done   : one-cycle pulse after the last word has been compared
//   idx    : index of the largest word; strictly-greater wins, so ties keep the lowest index
module accel_argmax #(
  parameter int DATA_W = 32,
  parameter int NCLASS = 10,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NCLASS*DATA_W-1:0] scores,
  output logic                     done,
  output logic [IDX_W-1:0]         idx
);

  logic signed [DATA_W-1:0] score_w [NCLASS];
  logic signed [DATA_W-1:0] best;
  logic signed [DATA_W-1:0] cur;
  logic [IDX_W-1:0]         k;
  logic                     running;
  logic                     take;

  for (genvar g = 0; g < NCLASS; g++) begin : g_unpack
    assign score_w[g] = signed'(scores[DATA_W*g +: DATA_W]);
  end

  always_comb begin
    cur  = score_w[k];
    take = running && ((k == '0) || (cur > best));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      k       <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running <= 1'b1;
        k       <= '0;
      end else if (running) begin
        if (k == IDX_W'(NCLASS - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          k <= k + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      best <= cur;
      idx  <= k;
    end
  end

endmodule

// File: rtl/accel_mmio_ctrl.sv
// accel_mmio_ctrl: picoRV32 native-bus slave in front of the MNIST NN accelerator.
// Owns the 784-word pixel buffer, sequences an inference (accelerator reset pulse,
// wait for acc_ready, latch 10 scores, argmax) and exposes status/results.
//   clk, reset            : clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb -> mem_ready/mem_rdata : picoRV32 native bus, 1-cycle latency
//   acc_image             : pixel buffer, word i at [32*i +: 32]
//   acc_rst               : active-high accelerator reset
//   acc_ready, acc_result : accelerator done flag and 10 signed scores
//   irq                   : done & irq_en
module accel_mmio_ctrl
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0200_0000,
  parameter int          RST_CYCLES = 4,
  parameter logic [31:0] TIMEOUT    = 32'd200000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NPIX*DATA_W-1:0]   acc_image,
  output logic                     acc_rst,
  input  logic                     acc_ready,
  input  logic [NCLASS*DATA_W-1:0] acc_result,
  output logic                     irq
);

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [3:0]        strb);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [DATA_W-1:0]        pix [NPIX];
  logic signed [DATA_W-1:0] score_q [NCLASS];
  logic signed [DATA_W-1:0] res_w [NCLASS];
  logic [NCLASS*DATA_W-1:0] score_flat;

  state_t          state, state_n;
  logic [15:0]     rst_cnt;
  logic            first_run;
  logic [31:0]     cycles, cyc_inc;
  logic            done, error, irq_en, busy;
  logic [IDX_W-1:0] class_q;

  logic [31:0]     addr_off;
  logic [11:0]     off;
  logic            hit, vld_p0, wr_req;
  logic [9:0]      pix_idx;
  logic [IDX_W-1:0] sidx;
  logic            is_pix, is_ctrl, is_status, is_class, is_cycles, is_score;
  logic [31:0]     rdata_p0;
  logic            start, start_ok, start_bad, pix_wr, pix_bad, w1c_done, w1c_err;
  logic            run_hit, timeout_hit, enter_done;
  logic            am_done;
  logic [IDX_W-1:0] am_idx;

  for (genvar g = 0; g < NPIX; g++) begin : g_img
    assign acc_image[DATA_W*g +: DATA_W] = pix[g];
  end

  for (genvar g = 0; g < NCLASS; g++) begin : g_score
    assign res_w[g] = signed'(acc_result[DATA_W*g +: DATA_W]);
    assign score_flat[DATA_W*g +: DATA_W] = score_q[g];
  end

  // Request stage: decode the bus request presented this cycle.
  always_comb begin
    addr_off  = mem_addr - BASE;
    off       = addr_off[11:0];
    hit       = (mem_addr >= BASE) && (addr_off < 32'h0000_1000);
    vld_p0    = mem_valid && hit && !mem_ready;
    wr_req    = (mem_wstrb != 4'b0000);
    pix_idx   = off[11:2];
    // Score words sit at word indices 0x314..0x31D; their low nibble minus 4 is the score index.
    sidx      = off[5:2] - 4'd4;
    is_pix    = (off < OFF_CTRL);
    is_ctrl   = (off[11:2] == OFF_CTRL[11:2]);
    is_status = (off[11:2] == OFF_STATUS[11:2]);
    is_class  = (off[11:2] == OFF_CLASS[11:2]);
    is_cycles = (off[11:2] == OFF_CYCLES[11:2]);
    is_score  = (off >= OFF_SCORE) && (off < OFF_SCORE_LIMIT);

    busy      = (state == S_ACC_RST) || (state == S_RUN) || (state == S_ARGMAX);
    start     = vld_p0 && wr_req && is_ctrl && mem_wstrb[0] && mem_wdata[CTRL_START];
    start_ok  = start && !busy;
    start_bad = start && busy;
    pix_wr    = vld_p0 && wr_req && is_pix && !busy;
    pix_bad   = vld_p0 && wr_req && is_pix && busy;
    w1c_done  = vld_p0 && wr_req && is_status && mem_wstrb[0] && mem_wdata[ST_DONE];
    w1c_err   = vld_p0 && wr_req && is_status && mem_wstrb[0] && mem_wdata[ST_ERROR];

    rdata_p0 = '0;
    if (is_pix) begin
      rdata_p0 = pix[pix_idx];
    end else if (is_ctrl) begin
      rdata_p0[CTRL_IRQ_EN] = irq_en;
    end else if (is_status) begin
      rdata_p0[ST_BUSY]  = busy;
      rdata_p0[ST_DONE]  = done;
      rdata_p0[ST_ERROR] = error;
    end else if (is_class) begin
      rdata_p0[IDX_W-1:0] = class_q;
    end else if (is_cycles) begin
      rdata_p0 = cycles;
    end else if (is_score) begin
      rdata_p0 = score_q[sidx];
    end
  end

  always_comb begin
    state_n     = state;
    run_hit     = 1'b0;
    timeout_hit = 1'b0;
    cyc_inc     = sat_inc(cycles);
    case (state)
      S_IDLE:    if (start_ok) state_n = S_ACC_RST;
      S_ACC_RST: if (rst_cnt <= 16'd1) state_n = S_RUN;
      S_RUN: begin
        // acc_ready may still be high from the previous inference on the first RUN cycle.
        if (acc_ready && !first_run) begin
          run_hit = 1'b1;
          state_n = S_ARGMAX;
        end else if (cyc_inc >= TIMEOUT) begin
          timeout_hit = 1'b1;
          state_n     = S_DONE;
        end
      end
      S_ARGMAX:  if (am_done) state_n = S_DONE;
      S_DONE:    state_n = start_ok ? S_ACC_RST : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    enter_done = (state_n == S_DONE) && (state != S_DONE);
  end

  // Response stage: commit writes and register the read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPIX; i++) pix[i] <= '0;
    end else if (pix_wr) begin
      pix[pix_idx] <= byte_merge(pix[pix_idx], mem_wdata, mem_wstrb);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      first_run <= 1'b0;
      cycles    <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      irq_en    <= 1'b0;
      class_q   <= '0;
      acc_rst   <= 1'b1;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < NCLASS; i++) score_q[i] <= '0;
    end else begin
      state     <= state_n;
      acc_rst   <= (state_n == S_ACC_RST);
      mem_ready <= vld_p0;
      mem_rdata <= (vld_p0 && !wr_req) ? rdata_p0 : '0;

      if (start_ok) rst_cnt <= 16'(RST_CYCLES);
      else if (state == S_ACC_RST) rst_cnt <= rst_cnt - 16'd1;

      if (state == S_ACC_RST) begin
        first_run <= 1'b1;
        cycles    <= '0;
      end else if (state == S_RUN) begin
        first_run <= 1'b0;
        cycles    <= cyc_inc;
      end

      if (run_hit) begin
        for (int i = 0; i < NCLASS; i++) score_q[i] <= res_w[i];
      end

      if ((state == S_ARGMAX) && am_done) class_q <= am_idx;

      if (vld_p0 && wr_req && is_ctrl && mem_wstrb[0]) irq_en <= mem_wdata[CTRL_IRQ_EN];

      if (enter_done)    done <= 1'b1;
      else if (start_ok) done <= 1'b0;
      else if (w1c_done) done <= 1'b0;

      if (timeout_hit || start_bad || pix_bad) error <= 1'b1;
      else if (start_ok)                       error <= 1'b0;
      else if (w1c_err)                        error <= 1'b0;
    end
  end

  assign irq = done & irq_en;

  accel_argmax #(
    .DATA_W (DATA_W),
    .NCLASS (NCLASS),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .start  (run_hit),
    .scores (score_flat),
    .done   (am_done),
    .idx    (am_idx)
  );

endmodule

// File: tb/tb_accel_mmio_ctrl.sv
// tb_accel_mmio_ctrl: directed, table-driven bench for accel_mmio_ctrl.
// Register accesses come from a vector table; inference, busy-interference,
// timeout and mid-run reset are hand-written sequences. The accelerator is a
// small model that raises acc_ready a fixed number of cycles after acc_rst falls.
module tb_accel_mmio_ctrl;
  import accel_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] TMO  = 32'd1000;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     mem_valid = 1'b0;
  logic [31:0]              mem_addr = '0;
  logic [31:0]              mem_wdata = '0;
  logic [3:0]               mem_wstrb = '0;
  logic                     mem_ready;
  logic [31:0]              mem_rdata;
  logic [NPIX*DATA_W-1:0]   acc_image;
  logic                     acc_rst;
  logic                     acc_ready = 1'b0;
  logic [NCLASS*DATA_W-1:0] acc_result = '0;
  logic                     irq;

  int n_cmp = 0;
  int n_fail = 0;

  accel_mmio_ctrl #(
    .BASE       (BASE),
    .RST_CYCLES (4),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .acc_image  (acc_image),
    .acc_rst    (acc_rst),
    .acc_ready  (acc_ready),
    .acc_result (acc_result),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Accelerator model: acc_ready rises ready_delay cycles after the edge on
  // which acc_rst falls (ready_delay 0 = never). CYCLES then reads ready_delay+1,
  // because the controller counts the RUN cycle in which it sees acc_ready.
  int ready_delay = 50;
  int since_fall = 0;
  always @(posedge clk) begin
    #1;
    if (acc_rst) begin
      since_fall = 0;
      acc_ready  = 1'b0;
    end else begin
      since_fall++;
      if (ready_delay > 0 && since_fall >= ready_delay + 1) acc_ready = 1'b1;
    end
  end

  int rst_hi = 0;
  always @(negedge clk) if (acc_rst && reset) rst_hi++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts and ends at posedge+1; one idle cycle after each response.
  task automatic bus_xfer(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    mem_addr  = BASE + {20'h0, off};
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 20);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    logic [31:0] rd; int lat;
    bus_xfer(off, d, 4'hF, rd, lat);
    chk("wr_latency", lat, 1);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] rd; int lat;
    bus_xfer(off, 32'h0, 4'h0, rd, lat);
    chk(name, rd, exp);
  endtask

  task automatic wait_done(input int max_reads);
    logic [31:0] rd; int lat; logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_reads && !ok; i++) begin
      bus_xfer(OFF_STATUS, 32'h0, 4'h0, rd, lat);
      if (rd[ST_DONE]) ok = 1'b1;
    end
    chk("done_seen", {31'b0, ok}, 32'h1);
  endtask

  logic signed [31:0] sc [NCLASS];
  task automatic load_scores();
    for (int k = 0; k < NCLASS; k++) acc_result[32*k +: 32] = sc[k];
  endtask

  typedef struct {
    bit          is_wr;
    logic [11:0] off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    int lat, snap, hits;

    vecs[0]  = '{1'b1, 12'h000, 32'h0000_0011, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 12'hC3C, 32'h0000_00AB, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_0011};
    vecs[3]  = '{1'b0, 12'hC3C, 32'h0,         4'h0, 32'h0000_00AB};
    vecs[4]  = '{1'b1, 12'h004, 32'hAABB_CCDD, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 12'h004, 32'h1122_3344, 4'h5, 32'h0};
    vecs[6]  = '{1'b0, 12'h004, 32'h0,         4'h0, 32'hAA22_CC44};
    vecs[7]  = '{1'b1, 12'hC40, 32'h0000_0002, 4'hF, 32'h0};
    vecs[8]  = '{1'b0, 12'hC40, 32'h0,         4'h0, 32'h0000_0002};
    vecs[9]  = '{1'b1, 12'hC40, 32'h0000_0000, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 12'hC40, 32'h0,         4'h0, 32'h0000_0000};
    vecs[11] = '{1'b0, 12'hC44, 32'h0,         4'h0, 32'h0000_0000};
    vecs[12] = '{1'b1, 12'hD00, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[13] = '{1'b0, 12'hD00, 32'h0,         4'h0, 32'h0000_0000};
    vecs[14] = '{1'b0, 12'hC4C, 32'h0,         4'h0, 32'h0000_0000};
    vecs[15] = '{1'b0, 12'hC50, 32'h0,         4'h0, 32'h0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_acc_rst", {31'b0, acc_rst}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_image_nonzero", {31'b0, (acc_image != '0)}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_acc_rst", {31'b0, acc_rst}, 32'h0);
    rd_chk("rst_class", OFF_CLASS, 32'h0);

    // Register vectors
    for (int i = 0; i < 16; i++) begin
      bus_xfer(vecs[i].off, vecs[i].data, vecs[i].is_wr ? vecs[i].strb : 4'h0, rd, lat);
      chk($sformatf("vec%0d_latency", i), lat, 1);
      if (!vecs[i].is_wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    chk("image_word0", acc_image[31:0], 32'h0000_0011);
    chk("image_word783", acc_image[783*32 +: 32], 32'h0000_00AB);

    // Outside the window: no response
    hits = 0;
    mem_addr = BASE + 32'h0000_1000; mem_wstrb = 4'h0; mem_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (mem_ready) hits++; end
    mem_addr = BASE - 32'd4;
    repeat (5) begin @(posedge clk); #1; if (mem_ready) hits++; end
    mem_valid = 1'b0;
    chk("outside_window_acks", hits, 0);

    // Inference 1: ties resolve to the lowest index
    sc = '{32'sd5, -32'sd3, 32'sd9, 32'sd9, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    load_scores();
    ready_delay = 50;
    snap = rst_hi;
    wr(OFF_CTRL, 32'h1);
    rd_chk("inf1_status_busy", OFF_STATUS, 32'h1);
    wait_done(200);
    chk("inf1_acc_rst_cycles", rst_hi - snap, 4);
    rd_chk("inf1_status", OFF_STATUS, 32'h2);
    rd_chk("inf1_class", OFF_CLASS, 32'd2);
    rd_chk("inf1_cycles", OFF_CYCLES, 32'd51);
    rd_chk("inf1_score1", OFF_SCORE + 12'h004, 32'hFFFF_FFFD);
    chk("inf1_irq_off", {31'b0, irq}, 32'h0);

    // Inference 2: all negative, irq enabled
    for (int k = 0; k < NCLASS; k++) sc[k] = -32'sd100;
    sc[0] = -32'sd10; sc[1] = -32'sd2; sc[2] = -32'sd7;
    load_scores();
    wr(OFF_CTRL, 32'h3);
    chk("inf2_irq_cleared_on_start", {31'b0, irq}, 32'h0);
    wait_done(200);
    chk("inf2_irq", {31'b0, irq}, 32'h1);
    rd_chk("inf2_class", OFF_CLASS, 32'd1);
    wr(OFF_STATUS, 32'h2);
    chk("inf2_irq_after_w1c", {31'b0, irq}, 32'h0);
    rd_chk("inf2_status_after_w1c", OFF_STATUS, 32'h0);

    // Inference 3: pixel write and second start while running
    wr(12'h014, 32'h0000_0055);
    for (int k = 0; k < NCLASS; k++) sc[k] = 32'sd0;
    sc[9] = 32'sd7;
    load_scores();
    wr(OFF_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    wr(12'h014, 32'h0000_DEAD);
    wr(OFF_CTRL, 32'h1);
    chk("inf3_image_word5", acc_image[5*32 +: 32], 32'h0000_0055);
    wait_done(200);
    rd_chk("inf3_status", OFF_STATUS, 32'h6);
    rd_chk("inf3_pixel5", 12'h014, 32'h0000_0055);
    rd_chk("inf3_class", OFF_CLASS, 32'd9);
    rd_chk("inf3_cycles", OFF_CYCLES, 32'd51);

    // Inference 4: acc_ready never rises
    wr(OFF_STATUS, 32'h6);
    rd_chk("inf4_status_cleared", OFF_STATUS, 32'h0);
    for (int k = 0; k < NCLASS; k++) sc[k] = 32'sd100;
    load_scores();
    ready_delay = 0;
    wr(OFF_CTRL, 32'h1);
    wait_done(1500);
    rd_chk("tmo_status", OFF_STATUS, 32'h6);
    rd_chk("tmo_cycles", OFF_CYCLES, TMO);
    rd_chk("tmo_score9", OFF_SCORE + 12'h024, 32'd7);
    rd_chk("tmo_score0", OFF_SCORE, 32'd0);
    rd_chk("tmo_class", OFF_CLASS, 32'd9);

    // Reset asserted mid-RUN
    wr(OFF_STATUS, 32'h6);
    wr(OFF_CTRL, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("midrst_acc_rst", {31'b0, acc_rst}, 32'h1);
    chk("midrst_image_nonzero", {31'b0, (acc_image != '0)}, 32'h0);
    chk("midrst_mem_ready", {31'b0, mem_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    rd_chk("midrst_status", OFF_STATUS, 32'h0);
    rd_chk("midrst_pixel0", 12'h000, 32'h0);
    rd_chk("midrst_cycles", OFF_CYCLES, 32'h0);
    rd_chk("midrst_score9", OFF_SCORE + 12'h024, 32'h0);
    rd_chk("midrst_class", OFF_CLASS, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
